// File: rtl/instr_prefetch_buf.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buf
//
// Instruction prefetch buffer between a core fetch stage and a single-cycle,
// never-stalling instruction memory. Reads are issued ahead of the core into a
// small FIFO of {byte address, instruction} entries. A credit rule keeps the
// buffered + in-flight count within the FIFO depth. A redirect (branch_i)
// flushes everything and starts fetching at the new target in the same cycle.
//
// Configuration macro:
//   INSTR_PREFETCH_EN  defined   -> DEPTH = 2 (one instruction per cycle
//                                   sustained, plus one cycle of slack)
//                      undefined -> DEPTH = 1 (single register of storage)
//
// Parameters:
//   ADDR_WIDTH  instruction-memory word-address width (MSB = boot region)
//   BOOT_ADDR   byte address of the first fetch after reset
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   fetch_enable_i  new memory reads are allowed only while high
//   branch_i        redirect request, target byte address on branch_addr_i
//   valid_o/ready_i instruction handshake towards the core
//   rdata_o/addr_o  instruction word and its byte address
//   mem_en_o        memory read strobe
//   mem_addr_o      memory word address
//   mem_we_o        always 0 (read-only port)
//   mem_be_o        always 4'hF
//   mem_rdata_i     read data, valid exactly one cycle after mem_en_o
//
// Handshake: valid_o/ready_i follow strict valid/ready rules. An instruction
// transfers (pops) in every cycle where valid_o && ready_i at the rising clock
// edge. While valid_o is high and ready_i low, addr_o/rdata_o hold the same
// instruction on following cycles unless branch_i or rst discards it.
// -----------------------------------------------------------------------------
module instr_prefetch_buf #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_8000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_enable_i,
   input  logic                  branch_i,
   input  logic [31:0]           branch_addr_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [31:0]           rdata_o,
   output logic [31:0]           addr_o,
   output logic                  mem_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   input  logic [31:0]           mem_rdata_i
);

`ifdef INSTR_PREFETCH_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif

   // Each FIFO entry is {addr[31:0], instr[31:0]}; entry 0 is the head.
   localparam int unsigned EW      = 64;
   localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

   // Registered state
   logic [31:0]         fptr_q,          fptr_d;
   logic [DEPTH*EW-1:0] fifo_q,          fifo_d;
   logic [1:0]          count_q,         count_d;
   logic                inflight_q,      inflight_d;
   logic                stale_q,         stale_d;
   logic [31:0]         inflight_addr_q, inflight_addr_d;

   // Combinational helpers
   logic [31:0] branch_tgt;
   logic        fifo_empty;
   logic        resp_ok;
   logic        valid;
   logic        pop;
   logic        head_pop;
   logic        push;
   logic [2:0]  occupancy;
   logic        issue;
   logic [1:0]  wr_idx;

   // Handshake, credit and output selection
   always_comb begin
      // Masking instead of slicing keeps the whole redirect bus in use; the
      // low two bits are simply dropped.
      branch_tgt = branch_addr_i & 32'hFFFF_FFFC;
      fifo_empty = (count_q == 2'd0);

      // The read issued last cycle returns now. A redirect in this cycle
      // discards it on the spot, so it is never presented or stored.
      resp_ok    = inflight_q & ~stale_q & ~branch_i;

      valid      = ~branch_i & (~fifo_empty | resp_ok);
      pop        = valid & ready_i;
      head_pop   = pop & ~fifo_empty;

      // The response goes into the FIFO unless it is bypassed straight out and
      // consumed in the same cycle.
      push       = resp_ok & ~(fifo_empty & pop);

      // Entries that would be held after this cycle if a new read were issued
      // now must stay below DEPTH: the read lands next cycle.
      occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

      // A redirect always gets its read out (the FIFO is flushed this cycle,
      // so credit is free). Nothing issues while rst is high.
      issue      = ~rst & fetch_enable_i & (branch_i | (occupancy < DEPTH_C));

      valid_o    = valid;
      rdata_o    = 32'h0;
      addr_o     = 32'h0;
      if (valid) begin
         if (!fifo_empty) begin
            addr_o  = fifo_q[EW-1:32];
            rdata_o = fifo_q[31:0];
         end else begin
            addr_o  = inflight_addr_q;
            rdata_o = mem_rdata_i;
         end
      end

      mem_en_o   = issue;
      mem_addr_o = branch_i ? branch_tgt[ADDR_WIDTH+1:2] : fptr_q[ADDR_WIDTH+1:2];
      mem_we_o   = 1'b0;
      mem_be_o   = 4'hF;
   end

   // Next-state logic
   always_comb begin
      fifo_d = fifo_q;
      if (head_pop) begin
         fifo_d = fifo_q >> EW;
      end
      // Tail slot is computed after the head pop, so push+pop stays in place.
      wr_idx = count_q - {1'b0, head_pop};
      if (push) begin
         fifo_d[int'(wr_idx)*EW +: EW] = {inflight_addr_q, mem_rdata_i};
      end

      if (branch_i) begin
         count_d = 2'd0;
      end else begin
         count_d = count_q + {1'b0, push} - {1'b0, head_pop};
      end

      inflight_d      = issue;
      inflight_addr_d = branch_i ? branch_tgt : fptr_q;

      // With a one-cycle, non-stalling memory the response outstanding at a
      // redirect arrives in the redirect cycle itself and is dropped there by
      // resp_ok. The read issued alongside the redirect belongs to the new
      // stream, so the slot is never left marked stale.
      stale_d = 1'b0;

      fptr_d = fptr_q;
      if (branch_i) begin
         fptr_d = issue ? (branch_tgt + 32'd4) : branch_tgt;
      end else if (issue) begin
         fptr_d = fptr_q + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fptr_q          <= BOOT_ADDR;
         fifo_q          <= '0;
         count_q         <= 2'd0;
         inflight_q      <= 1'b0;
         stale_q         <= 1'b0;
         inflight_addr_q <= 32'h0;
      end else begin
         fptr_q          <= fptr_d;
         fifo_q          <= fifo_d;
         count_q         <= count_d;
         inflight_q      <= inflight_d;
         stale_q         <= stale_d;
         inflight_addr_q <= inflight_addr_d;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_buf
//
// Drives directed scenarios into instr_prefetch_buf with a behavioural memory
// (one-cycle read, data derived from the word address). A queue-based model of
// the prefetch behaviour is compared against the DUT every cycle, and a set of
// literal expectations pins the boot, stall, redirect, wrap and reset cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_prefetch_buf;

`ifdef INSTR_PREFETCH_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int          AW   = 14;
   localparam logic [31:0] BOOT = 32'h0000_8000;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_enable_i;
   logic          branch_i;
   logic [31:0]   branch_addr_i;
   logic          valid_o;
   logic          ready_i;
   logic [31:0]   rdata_o;
   logic [31:0]   addr_o;
   logic          mem_en_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_we_o;
   logic [3:0]    mem_be_o;
   logic [31:0]   mem_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   instr_prefetch_buf #(
      .ADDR_WIDTH (AW),
      .BOOT_ADDR  (BOOT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_enable_i (fetch_enable_i),
      .branch_i       (branch_i),
      .branch_addr_i  (branch_addr_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .rdata_o        (rdata_o),
      .addr_o         (addr_o),
      .mem_en_o       (mem_en_o),
      .mem_addr_o     (mem_addr_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_rdata_i    (mem_rdata_i)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [31:0] mem_word(input logic [AW-1:0] w);
      return {w, 18'h0} ^ {18'h0, ~w} ^ 32'h3C00_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- memory model ----------------
   logic          last_en;
   logic [AW-1:0] last_addr;

   always @(posedge clk) begin
      #1;
      mem_rdata_i = last_en ? mem_word(last_addr) : 32'hBAD0_BAD0;
   end

   // ---------------- model + compare process ----------------
   logic [31:0] avail_q[$];   // responses received, not yet consumed
   logic        out_v;        // a read went out last cycle
   logic [31:0] out_a;        // its byte address
   logic [31:0] m_fptr;       // next sequential fetch byte address

   initial begin
      out_v     = 1'b0;
      out_a     = 32'h0;
      m_fptr    = BOOT;
      last_en   = 1'b0;
      last_addr = '0;
      forever begin
         @(negedge clk);
         last_en   = mem_en_o;
         last_addr = mem_addr_o;
         if (rst) begin
            check("rst_valid_o", 32'(valid_o), 32'd0);
            check("rst_rdata_o", rdata_o, 32'd0);
            check("rst_addr_o", addr_o, 32'd0);
            check("rst_mem_en_o", 32'(mem_en_o), 32'd0);
            avail_q.delete();
            out_v  = 1'b0;
            m_fptr = BOOT;
         end else begin
            logic        e_valid;
            logic [31:0] e_addr;
            logic        e_pop;
            logic        e_issue;
            logic [31:0] tgt;
            int          occ;
            tgt     = branch_addr_i & ~32'h3;
            e_valid = 1'b0;
            e_addr  = 32'h0;
            if (!branch_i) begin
               if (avail_q.size() > 0) begin
                  e_valid = 1'b1;
                  e_addr  = avail_q[0];
               end else if (out_v) begin
                  e_valid = 1'b1;
                  e_addr  = out_a;
               end
            end
            e_pop   = e_valid && ready_i;
            occ     = avail_q.size() + int'(out_v) - int'(e_pop);
            e_issue = fetch_enable_i && (branch_i || occ < DEPTH);

            check("valid_o", 32'(valid_o), 32'(e_valid));
            if (e_valid && valid_o) begin
               check("addr_o", addr_o, e_addr);
               check("rdata_o", rdata_o, mem_word(e_addr[AW+1:2]));
            end
            check("mem_en_o", 32'(mem_en_o), 32'(e_issue));
            if (e_issue && mem_en_o) begin
               check("mem_addr_o", 32'(mem_addr_o),
                     32'(branch_i ? tgt[AW+1:2] : m_fptr[AW+1:2]));
            end
            check("mem_we_o", 32'(mem_we_o), 32'd0);
            check("mem_be_o", 32'(mem_be_o), 32'hF);

            if (branch_i) begin
               avail_q.delete();
            end else begin
               if (out_v) avail_q.push_back(out_a);
               if (e_pop) void'(avail_q.pop_front());
            end
            out_v = e_issue;
            out_a = branch_i ? tgt : m_fptr;
            if (branch_i) m_fptr = fetch_enable_i ? tgt + 32'd4 : tgt;
            else if (e_issue) m_fptr = m_fptr + 32'd4;
         end
      end
   end

   // ---------------- directed stimulus + literal expectations ----------------
   logic [47:0] rdy_pat = 48'hF3CA5E0F196B;
   logic [47:0] fen_pat = 48'hFFF7EFFF3FDF;
   int reads;

   initial begin
      rst            = 1'b1;
      fetch_enable_i = 1'b1;
      ready_i        = 1'b1;
      branch_i       = 1'b0;
      branch_addr_i  = 32'h0;
      cyc(3);
      @(negedge clk);
      check("reset_valid", 32'(valid_o), 32'd0);
      check("reset_mem_en", 32'(mem_en_o), 32'd0);

      // Boot stream, ready high: 0x2000 requested, then 0x8000/4/8 delivered.
      cyc(); rst = 1'b0;
      @(negedge clk);
      check("boot_mem_en", 32'(mem_en_o), 32'd1);
      check("boot_mem_addr", 32'(mem_addr_o), 32'h2000);
      cyc(); @(negedge clk);
      check("boot_valid", 32'(valid_o), 32'd1);
      check("boot_addr0", addr_o, 32'h8000);
      cyc(); @(negedge clk);
      check("boot_addr1", addr_o, 32'h8004);
      cyc(); @(negedge clk);
      check("boot_addr2", addr_o, 32'h8008);

      // Fresh start with the core stalled: reads stop after DEPTH.
      cyc(); rst = 1'b1; ready_i = 1'b0;
      cyc(2);
      cyc(); rst = 1'b0;
      reads = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_en_o) reads++;
         cyc();
      end
      check("stall_reads", 32'(reads), 32'(DEPTH));
      @(negedge clk);
      check("stall_idle_mem_en", 32'(mem_en_o), 32'd0);
      cyc(); ready_i = 1'b1;
      @(negedge clk);
      check("drain_valid", 32'(valid_o), 32'd1);
      check("drain_addr0", addr_o, 32'h8000);
      cyc(); @(negedge clk);
      check("drain_addr1", addr_o, 32'h8004);

      // Redirect to 0x103 with data buffered and a read in flight.
      cyc(); branch_i = 1'b1; branch_addr_i = 32'h0000_0103; ready_i = 1'b0;
      @(negedge clk);
      check("br_mem_addr", 32'(mem_addr_o), 32'h040);
      check("br_mem_en", 32'(mem_en_o), 32'd1);
      check("br_valid", 32'(valid_o), 32'd0);
      cyc(); branch_i = 1'b0; ready_i = 1'b1;
      @(negedge clk);
      check("br_next_valid", 32'(valid_o), 32'd1);
      check("br_next_addr", addr_o, 32'h100);
      cyc(); @(negedge clk);
      check("br_next_addr2", addr_o, 32'h104);

      // Redirect while fetching is disabled: no read, pointer lands on target.
      cyc(); fetch_enable_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h0000_0203;
      @(negedge clk);
      check("brdis_mem_en", 32'(mem_en_o), 32'd0);
      check("brdis_valid", 32'(valid_o), 32'd0);
      cyc(); branch_i = 1'b0; fetch_enable_i = 1'b1;
      @(negedge clk);
      check("brdis_resume_addr", 32'(mem_addr_o), 32'h080);
      check("brdis_resume_valid", 32'(valid_o), 32'd0);
      cyc(); @(negedge clk);
      check("brdis_first_addr", addr_o, 32'h200);

      // Fetch pointer wraps from 0xFFFF_FFFC to 0.
      cyc(); branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFE;
      @(negedge clk);
      check("wrap_mem_addr", 32'(mem_addr_o), 32'h3FFF);
      cyc(); branch_i = 1'b0;
      @(negedge clk);
      check("wrap_next_mem_addr", 32'(mem_addr_o), 32'h0000);
      check("wrap_addr_top", addr_o, 32'hFFFF_FFFC);
      cyc(); @(negedge clk);
      check("wrap_addr_zero", addr_o, 32'h0);

      // Reset in the middle of a stall with the buffer full.
      cyc(); ready_i = 1'b0;
      cyc(4);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(valid_o), 32'd0);
      check("async_rst_mem_en", 32'(mem_en_o), 32'd0);
      cyc(2); rst = 1'b0; ready_i = 1'b1;
      @(negedge clk);
      check("rerst_mem_addr", 32'(mem_addr_o), 32'h2000);
      cyc(); @(negedge clk);
      check("rerst_addr", addr_o, 32'h8000);

      // Mixed ready / fetch-enable pattern with two redirects, model-checked.
      for (int i = 0; i < 48; i++) begin
         cyc();
         ready_i        = rdy_pat[i];
         fetch_enable_i = fen_pat[i];
         branch_i       = (i == 20) || (i == 33);
         branch_addr_i  = (i == 20) ? 32'h0000_1237 : 32'h0000_3FF0;
      end
      cyc(); branch_i = 1'b0; fetch_enable_i = 1'b1; ready_i = 1'b1;
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
